// File: rtl/pwm_pkg.sv
// Register map and CTRL bit positions shared by the PWM bank and its timebase.
package pwm_pkg;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_PRESCALE = 6'h01;
    localparam logic [5:0] ADDR_OUT_EN   = 6'h04;
    localparam logic [5:0] ADDR_PWM_EN   = 6'h08;
    localparam logic [5:0] ADDR_POL      = 6'h0C;
    localparam logic [5:0] ADDR_DUTY     = 6'h20;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CENTER_BIT = 1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and edge/centre-aligned PWM counter; flags the cycle on which a period begins.
// state    | meaning
// DIR_UP   | counting 0..MAX (the only state used in edge mode)
// DIR_DOWN | centre mode falling half, MAX-1 down to 1
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int RES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           center,
    input  logic           restart,
    input  logic [7:0]     prescale,
    output logic [RES-1:0] cnt,
    output logic           tick,
    output logic           period_begin
);

    localparam logic [RES-1:0] MAX = '1;
    localparam logic [RES-1:0] ONE = RES'(1);

    dir_e           dir_q, dir_d;
    logic [7:0]     presc_q, presc_d;
    logic [RES-1:0] cnt_q, cnt_d;
    logic           wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q   <= DIR_UP;
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            dir_q   <= dir_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        dir_d   = dir_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        tick    = en && !restart && (presc_q >= prescale);
        if (restart || !en) begin
            dir_d   = DIR_UP;
            presc_d = '0;
            cnt_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            if (!center) begin
                dir_d = DIR_UP;
                wrap  = (cnt_q == MAX);
                cnt_d = cnt_q + ONE;
            end else begin
                case (dir_q)
                    DIR_UP: begin
                        if (cnt_q == MAX) begin
                            dir_d = DIR_DOWN;
                            cnt_d = MAX - ONE;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                    DIR_DOWN: begin
                        cnt_d = cnt_q - ONE;
                        if (cnt_q == ONE) begin
                            dir_d = DIR_UP;
                            wrap  = 1'b1;
                        end
                    end
                    default: dir_d = DIR_UP;
                endcase
            end
        end else begin
            presc_d = presc_q + 8'd1;
        end
        // restart already implies the bank is (being) enabled
        period_begin = restart || wrap;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: byte-wide register file, shared timebase, and per-channel
// double-buffered duty compare with output enable / static-high / polarity control.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int RES    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [5:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam int             NBYTES = NUM_CH / 8;
    localparam logic [RES-1:0] MAX    = '1;

    logic              en_q, en_d;
    logic              center_q, center_d;
    logic [7:0]        presc_q, presc_d;
    logic [NUM_CH-1:0] out_en_q, out_en_d;
    logic [NUM_CH-1:0] pwm_en_q, pwm_en_d;
    logic [NUM_CH-1:0] pol_q, pol_d;
    logic              period_start_q;
    logic              wr_ctrl, wr_presc, restart;
    logic [RES-1:0]    cnt;
    logic              unused_tick;
    logic              period_begin;

    always_comb begin
        wr_ctrl  = wr_en && (wr_addr == ADDR_CTRL);
        wr_presc = wr_en && (wr_addr == ADDR_PRESCALE);
        en_d     = wr_ctrl ? wr_data[CTRL_EN_BIT] : en_q;
        center_d = wr_ctrl ? wr_data[CTRL_CENTER_BIT] : center_q;
        presc_d  = wr_presc ? wr_data : presc_q;
        out_en_d = out_en_q;
        pwm_en_d = pwm_en_q;
        pol_d    = pol_q;
        for (int k = 0; k < NBYTES; k++) begin
            if (wr_en && (wr_addr == ADDR_OUT_EN + 6'(k))) out_en_d[8*k +: 8] = wr_data;
            if (wr_en && (wr_addr == ADDR_PWM_EN + 6'(k))) pwm_en_d[8*k +: 8] = wr_data;
            if (wr_en && (wr_addr == ADDR_POL + 6'(k)))    pol_d[8*k +: 8]    = wr_data;
        end
        // Any CTRL/PRESCALE write that leaves the bank enabled re-aligns the period;
        // this also covers the EN 0->1 case.
        restart = (wr_ctrl || wr_presc) && en_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q           <= 1'b0;
            center_q       <= 1'b0;
            presc_q        <= '0;
            out_en_q       <= '0;
            pwm_en_q       <= '0;
            pol_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            en_q           <= en_d;
            center_q       <= center_d;
            presc_q        <= presc_d;
            out_en_q       <= out_en_d;
            pwm_en_q       <= pwm_en_d;
            pol_q          <= pol_d;
            period_start_q <= period_begin;
        end
    end

    pwm_timebase #(
        .RES(RES)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en_d),
        .center      (center_q),
        .restart     (restart),
        .prescale    (presc_q),
        .cnt         (cnt),
        .tick        (unused_tick),
        .period_begin(period_begin)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [RES-1:0] shadow_q, active_q;
        logic           raw, out_d, out_q;

        assign raw   = en_q && ((active_q == MAX) || (cnt < active_q));
        assign out_d = out_en_q[i] && (!pwm_en_q[i] || (raw ^ pol_q[i]));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q <= '0;
                active_q <= '0;
                out_q    <= 1'b0;
            end else begin
                if (wr_en && (wr_addr == ADDR_DUTY + 6'(i))) shadow_q <= wr_data[RES-1:0];
                // Reload sees the pre-write shadow, so a same-cycle write waits a period
                if (period_begin) active_q <= shadow_q;
                out_q <= out_d;
            end
        end

        assign pwm_out[i] = out_q;
    end

    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: register writes at negedge, output counting at negedge,
// expected counts worked out by hand from the counter sequences.
module tb_pwm_bank;

    localparam int NUM_CH = 16;
    localparam int RES    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;

    int n_checks = 0;
    int n_pass   = 0;
    int highs, starts, first_ps, last_ps, pwm_at_ps;

    pwm_bank #(
        .NUM_CH(NUM_CH),
        .RES   (RES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic sample(input int n, input int ch);
        highs     = 0;
        starts    = 0;
        first_ps  = -1;
        last_ps   = -1;
        pwm_at_ps = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (pwm_out[ch]) highs++;
            if (period_start) begin
                starts++;
                if (first_ps < 0) begin
                    first_ps  = k;
                    pwm_at_ps = int'(pwm_out[ch]);
                end
                last_ps = k;
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_period_start", int'(period_start), 0);
        rst_n = 1'b1;
        sample(20, 0);
        check("idle_starts", starts, 0);
        check("idle_highs", highs, 0);

        // Edge mode, prescale 0, duty 64 on ch0
        wr(6'h01, 8'd0);
        wr(6'h04, 8'h01);
        wr(6'h08, 8'h01);
        wr(6'h20, 8'd64);
        wr(6'h00, 8'h01);
        check("edge_en_ps", int'(period_start), 1);
        sample(512, 0);
        check("edge_highs", highs, 128);
        check("edge_starts", starts, 2);
        check("edge_first_ps", first_ps, 256);
        check("edge_last_ps", last_ps, 512);
        check("edge_pwm_at_ps", pwm_at_ps, 0);

        // Centre mode: rising 0..63 plus falling 63..1 gives 127 high per 510-cycle period
        wr(6'h00, 8'h03);
        check("ctr_ps", int'(period_start), 1);
        sample(1020, 0);
        check("ctr_highs", highs, 254);
        check("ctr_starts", starts, 2);
        check("ctr_first_ps", first_ps, 510);
        check("ctr_last_ps", last_ps, 1020);
        check("ctr_pwm_at_ps", pwm_at_ps, 1);

        // Mid-period duty change 64 -> 200
        wr(6'h00, 8'h01);
        sample(100, 0);
        check("mid_pre_highs", highs, 64);
        check("mid_pre_starts", starts, 0);
        wr(6'h20, 8'd200);
        sample(155, 0);
        check("mid_rest_highs", highs, 0);
        check("mid_rest_starts", starts, 1);
        sample(256, 0);
        check("mid_next_highs", highs, 200);
        check("mid_next_first_ps", first_ps, 256);

        // Duty write on the exact period-begin edge takes effect one period later
        sample(255, 0);
        wr(6'h20, 8'd30);
        check("same_edge_ps", int'(period_start), 1);
        sample(256, 0);
        check("same_edge_old_duty", highs, 200);
        sample(256, 0);
        check("same_edge_new_duty", highs, 30);

        // Unmapped and absent-byte/channel writes must not disturb anything
        wr(6'h02, 8'h03);
        wr(6'h10, 8'h03);
        wr(6'h30, 8'h00);
        wr(6'h06, 8'h00);
        wr(6'h0E, 8'hFF);
        wr(6'h00, 8'h01);
        sample(256, 0);
        check("unmapped_highs", highs, 30);
        check("unmapped_starts", starts, 1);
        check("unmapped_first_ps", first_ps, 256);

        // Duty extremes and polarity
        wr(6'h20, 8'd0);
        wr(6'h00, 8'h01);
        sample(512, 0);
        check("duty0_highs", highs, 0);
        wr(6'h20, 8'd255);
        wr(6'h00, 8'h01);
        sample(512, 0);
        check("dutymax_highs", highs, 512);
        wr(6'h0C, 8'h01);
        sample(512, 0);
        check("dutymax_inv_highs", highs, 0);
        wr(6'h20, 8'd0);
        wr(6'h00, 8'h01);
        sample(256, 0);
        check("duty0_inv_highs", highs, 256);

        // Static-high ch9, across EN=1 and EN=0
        wr(6'h05, 8'h02);
        sample(300, 9);
        check("ch9_static_en1", highs, 300);
        wr(6'h00, 8'h00);
        sample(300, 9);
        check("ch9_static_en0", highs, 300);
        check("dis_starts", starts, 0);
        sample(50, 0);
        check("dis_ch0_inv", highs, 50);
        wr(6'h05, 8'h00);
        sample(50, 9);
        check("ch9_out_dis", highs, 0);

        // Prescale 3: 1024-cycle period, then asynchronous reset mid-period
        wr(6'h0C, 8'h00);
        wr(6'h20, 8'd64);
        wr(6'h01, 8'd3);
        wr(6'h00, 8'h01);
        check("presc_ps", int'(period_start), 1);
        sample(2048, 0);
        check("presc_highs", highs, 512);
        check("presc_starts", starts, 2);
        check("presc_first_ps", first_ps, 1024);
        check("presc_last_ps", last_ps, 2048);
        sample(50, 0);
        check("pre_rst_pwm0", int'(pwm_out[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_pwm_out", int'(pwm_out), 0);
        check("rst_async_ps", int'(period_start), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sample(20, 0);
        check("post_rst_idle_starts", starts, 0);
        wr(6'h00, 8'h01);
        check("post_rst_en_ps", int'(period_start), 1);
        sample(512, 0);
        check("post_rst_highs", highs, 0);
        check("post_rst_starts", starts, 2);
        check("post_rst_first_ps", first_ps, 256);
        wr(6'h04, 8'h01);
        wr(6'h08, 8'h01);
        wr(6'h00, 8'h01);
        sample(256, 0);
        check("post_rst_duty_cleared", highs, 0);
        check("post_rst_period", first_ps, 256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
